// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Sequencer for the alarm-clock time counters. Produces the Enable, Up and
// load strobes for the seconds / minutes / hours counter chain.
//   RUN     : a prescaled tick advances seconds, carrying into minutes and
//             hours when the lower counters sit at their terminal value.
//   SET_HR  : each Inc press steps the hours counter by one.
//   SET_MIN : each Inc press steps the minutes counter by one. Leaving this
//             state zeroes the seconds counter and realigns the prescaler.
//
// Parameters
//   TICK_DIV    Clk cycles per Tick (>= 2)
//
// Optional feature
//   BLINK_EN    when defined, Blink toggles on each Tick while a set state is
//               active (starting at 1 on entry); when undefined Blink is tied 0.
//
// Ports
//   Clk         in   system clock, all logic on posedge
//   Clr         in   synchronous active-high reset
//   Mode_Btn    in   mode button (synchronized level)
//   Inc_Btn     in   increment button (synchronized level)
//   Sec_Max     in   seconds counter at terminal value
//   Min_Max     in   minutes counter at terminal value
//   Tick        out  1-cycle pulse every TICK_DIV cycles
//   Sec_En      out  seconds counter enable strobe
//   Min_En      out  minutes counter enable strobe
//   Hr_En       out  hours counter enable strobe
//   Up          out  count-up command accompanying tick/Inc enables
//   Sec_LD      out  seconds counter load-zero strobe
//   Mode_State  out  00 RUN, 01 SET_HR, 10 SET_MIN (also the FSM debug view)
//   Blink       out  display blink for the digits being set
//
// Handshake / strobe semantics: every strobe output is a registered single
// cycle pulse. A button press is a rising level (Btn & ~Btn_q) seen at a
// posedge; its strobe is visible in the cycle after that edge. There is no
// back-pressure: the counter chain is expected to accept every strobe.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Mode_Btn,
  input  logic       Inc_Btn,
  input  logic       Sec_Max,
  input  logic       Min_Max,
  output logic       Tick,
  output logic       Sec_En,
  output logic       Min_En,
  output logic       Hr_En,
  output logic       Up,
  output logic       Sec_LD,
  output logic [1:0] Mode_State,
  output logic       Blink
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          mode_q;
  logic          inc_q;

  logic          wrap;
  logic          mode_press;
  logic          inc_press;

  logic          tick_d;
  logic          sec_en_d;
  logic          min_en_d;
  logic          hr_en_d;
  logic          up_d;
  logic          sec_ld_d;

  assign Mode_State = state_q;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    mode_press = Mode_Btn & ~mode_q;
    inc_press  = Inc_Btn & ~inc_q;

    state_d  = state_q;
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    tick_d   = wrap;
    sec_en_d = 1'b0;
    min_en_d = 1'b0;
    hr_en_d  = 1'b0;
    up_d     = 1'b0;
    sec_ld_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Tick enables are issued even when a Mode press moves us out of RUN
        // on the same edge.
        if (wrap) begin
          sec_en_d = 1'b1;
          min_en_d = Sec_Max;
          hr_en_d  = Sec_Max & Min_Max;
          up_d     = 1'b1;
        end
        if (mode_press) begin
          state_d = ST_SET_HR;
        end
      end

      ST_SET_HR: begin
        // Mode takes priority; a simultaneous Inc press is dropped.
        if (mode_press) begin
          state_d = ST_SET_MIN;
        end else if (inc_press) begin
          hr_en_d = 1'b1;
          up_d    = 1'b1;
        end
      end

      ST_SET_MIN: begin
        if (mode_press) begin
          // Zero the seconds counter (enable + load, no Up) and restart the
          // prescaler so the first RUN tick lands a full period later. A wrap
          // coinciding with this edge is swallowed for the same reason.
          state_d  = ST_RUN;
          sec_ld_d = 1'b1;
          sec_en_d = 1'b1;
          cnt_d    = '0;
          tick_d   = 1'b0;
        end else if (inc_press) begin
          min_en_d = 1'b1;
          up_d     = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to RUN silently.
        state_d = ST_RUN;
        tick_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, prescaler, button history and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      // History starts high so a button held through reset is not a press.
      mode_q  <= 1'b1;
      inc_q   <= 1'b1;
      Tick    <= 1'b0;
      Sec_En  <= 1'b0;
      Min_En  <= 1'b0;
      Hr_En   <= 1'b0;
      Up      <= 1'b0;
      Sec_LD  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= Mode_Btn;
      inc_q   <= Inc_Btn;
      Tick    <= tick_d;
      Sec_En  <= sec_en_d;
      Min_En  <= min_en_d;
      Hr_En   <= hr_en_d;
      Up      <= up_d;
      Sec_LD  <= sec_ld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink
  // ---------------------------------------------------------------------------
`ifdef BLINK_EN
  logic blink_d;

  always_comb begin
    blink_d = 1'b0;
    if (state_d != state_q) begin
      // Entering a set state shows the digits first; entering RUN clears.
      blink_d = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN);
    end else if ((state_q == ST_SET_HR) || (state_q == ST_SET_MIN)) begin
      blink_d = wrap ? ~Blink : Blink;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      Blink <= 1'b0;
    end else begin
      Blink <= blink_d;
    end
  end
`else
  assign Blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Directed bench for clock_set_ctrl with TICK_DIV = 4. A behavioural model
// tracks elapsed cycles since the last prescaler alignment, the user-visible
// mode and the button levels, and predicts every output each cycle; a compare
// process checks the DUT against it on each negedge. Directed sequences add
// literal expectations taken straight from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int TDIV = 4;

  logic       Clk;
  logic       Clr;
  logic       Mode_Btn;
  logic       Inc_Btn;
  logic       Sec_Max;
  logic       Min_Max;
  logic       Tick;
  logic       Sec_En;
  logic       Min_En;
  logic       Hr_En;
  logic       Up;
  logic       Sec_LD;
  logic [1:0] Mode_State;
  logic       Blink;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  clock_set_ctrl #(.TICK_DIV(TDIV)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .Mode_Btn   (Mode_Btn),
    .Inc_Btn    (Inc_Btn),
    .Sec_Max    (Sec_Max),
    .Min_Max    (Min_Max),
    .Tick       (Tick),
    .Sec_En     (Sec_En),
    .Min_En     (Min_En),
    .Hr_En      (Hr_En),
    .Up         (Up),
    .Sec_LD     (Sec_LD),
    .Mode_State (Mode_State),
    .Blink      (Blink)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Mode: 0 RUN, 1 SET_HR, 2 SET_MIN.
  // age counts cycles since the last alignment; a tick falls on every
  // TDIV-th cycle of it.
  // ---------------------------------------------------------------------------
  bit m_valid = 0;
  int m_mode, m_age, m_next_mode;
  bit m_mb_prev, m_ib_prev;
  bit m_tick_now, m_mode_hit, m_inc_hit;
  bit e_tick, e_sec, e_min, e_hr, e_up, e_ld, e_blink;

  always @(posedge Clk) begin
    if (Clr) begin
      m_valid = 1;
      m_mode = 0; m_age = 0;
      m_mb_prev = 1; m_ib_prev = 1;
      {e_tick, e_sec, e_min, e_hr, e_up, e_ld, e_blink} = '0;
    end else if (m_valid) begin
      m_tick_now = ((m_age % TDIV) == TDIV - 1);
      m_mode_hit = Mode_Btn && !m_mb_prev;
      m_inc_hit  = Inc_Btn && !m_ib_prev;
      {e_sec, e_min, e_hr, e_up, e_ld} = '0;
      e_tick = m_tick_now;
      m_next_mode = m_mode_hit ? (m_mode + 1) % 3 : m_mode;

      if (m_mode == 0 && m_tick_now) begin
        e_sec = 1; e_up = 1;
        e_min = Sec_Max;
        e_hr  = Sec_Max && Min_Max;
      end
      if (m_mode == 1 && !m_mode_hit && m_inc_hit) begin e_hr = 1; e_up = 1; end
      if (m_mode == 2 && !m_mode_hit && m_inc_hit) begin e_min = 1; e_up = 1; end

      if (m_mode == 2 && m_mode_hit) begin
        e_ld = 1; e_sec = 1; e_tick = 0;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end

`ifdef BLINK_EN
      if (m_next_mode == 0)            e_blink = 0;
      else if (m_next_mode != m_mode)  e_blink = 1;
      else if (m_tick_now)             e_blink = !e_blink;
`else
      e_blink = 0;
`endif
      m_mode = m_next_mode;
      m_mb_prev = Mode_Btn;
      m_ib_prev = Inc_Btn;
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("m_tick",   Tick,   e_tick);
      chk("m_sec_en", Sec_En, e_sec);
      chk("m_min_en", Min_En, e_min);
      chk("m_hr_en",  Hr_En,  e_hr);
      chk("m_up",     Up,     e_up);
      chk("m_sec_ld", Sec_LD, e_ld);
      chk("m_blink",  Blink,  e_blink);
      chk("m_mode",   Mode_State, 8'(m_mode));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on negedge)
  // ---------------------------------------------------------------------------
  task automatic press_mode();
    Mode_Btn = 1'b1;
    @(negedge Clk);
    Mode_Btn = 1'b0;
  endtask

  int min_cnt, sec_cnt, up_cnt;

  // ---------------------------------------------------------------------------
  // Directed sequences with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    Clr = 1'b1; Mode_Btn = 1'b0; Inc_Btn = 1'b0; Sec_Max = 1'b0; Min_Max = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_tick", Tick, 0);
    chk("rst_sec_en", Sec_En, 0);
    chk("rst_mode", Mode_State, 0);
    Clr = 1'b0;

    // Ticks at cycles 4, 8, 12 after release.
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      chk("t1_tick",   Tick,   (i % 4) == 0);
      chk("t1_sec_en", Sec_En, (i % 4) == 0);
      chk("t1_up",     Up,     (i % 4) == 0);
      chk("t1_min_en", Min_En, 0);
      chk("t1_hr_en",  Hr_En,  0);
    end

    // Full carry, then seconds-only carry.
    Sec_Max = 1'b1; Min_Max = 1'b1;
    repeat (4) @(negedge Clk);
    chk("t2_sec_en", Sec_En, 1);
    chk("t2_min_en", Min_En, 1);
    chk("t2_hr_en",  Hr_En,  1);
    Min_Max = 1'b0;
    repeat (4) @(negedge Clk);
    chk("t2b_min_en", Min_En, 1);
    chk("t2b_hr_en",  Hr_En,  0);
    Sec_Max = 1'b0;

    // Two Mode presses, then Inc held 10 cycles in SET_MIN.
    press_mode();
    chk("t3_mode_hr", Mode_State, 1);
    @(negedge Clk);
    press_mode();
    chk("t3_mode_min", Mode_State, 2);
    Inc_Btn = 1'b1;
    min_cnt = 0; sec_cnt = 0; up_cnt = 0;
    repeat (10) begin
      @(negedge Clk);
      min_cnt += int'(Min_En);
      sec_cnt += int'(Sec_En);
      up_cnt  += int'(Up);
    end
    Inc_Btn = 1'b0;
    chk("t3_min_pulses", 8'(min_cnt), 1);
    chk("t3_sec_pulses", 8'(sec_cnt), 0);
    chk("t3_up_pulses",  8'(up_cnt),  1);

    // Back to RUN, then SET_HR: single Inc, then Mode+Inc together.
    @(negedge Clk);
    press_mode();
    chk("t4_run", Mode_State, 0);
    chk("t4_ld",  Sec_LD, 1);
    @(negedge Clk);
    chk("t4_blink_run", Blink, 0);
    press_mode();
    chk("t4_set_hr", Mode_State, 1);
`ifdef BLINK_EN
    chk("t4_blink_entry", Blink, 1);
`endif
    @(negedge Clk);
    Inc_Btn = 1'b1;
    @(negedge Clk);
    Inc_Btn = 1'b0;
    chk("t4_hr_en", Hr_En, 1);
    chk("t4_hr_up", Up, 1);
    @(negedge Clk);
    Mode_Btn = 1'b1; Inc_Btn = 1'b1;
    @(negedge Clk);
    Mode_Btn = 1'b0; Inc_Btn = 1'b0;
    chk("t4_both_mode", Mode_State, 2);
    chk("t4_both_hr",   Hr_En, 0);
    chk("t4_both_min",  Min_En, 0);
    @(negedge Clk);
    press_mode();
    chk("t4_exit_ld",   Sec_LD, 1);
    chk("t4_exit_sec",  Sec_En, 1);
    chk("t4_exit_up",   Up, 0);
    chk("t4_exit_mode", Mode_State, 0);
    chk("t4_exit_blink", Blink, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      chk("t4_realign_tick", Tick, i == 4);
      chk("t4_ld_clear", Sec_LD, 0);
    end

    // Mode held through reset release.
    Mode_Btn = 1'b1; Clr = 1'b1;
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      chk("t5_held", Mode_State, 0);
    end
    Mode_Btn = 1'b0;
    @(negedge Clk);
    chk("t5_released", Mode_State, 0);
    press_mode();
    chk("t5_repress", Mode_State, 1);

    // Dwell in SET_HR across several ticks.
    repeat (12) @(negedge Clk);
    press_mode();
    chk("t6_set_min", Mode_State, 2);

    // Clr during an Inc strobe in SET_MIN.
    @(negedge Clk);
    Inc_Btn = 1'b1;
    @(negedge Clk);
    chk("t6_min_en", Min_En, 1);
    Clr = 1'b1; Inc_Btn = 1'b0;
    @(negedge Clk);
    chk("t6_clr_mode",  Mode_State, 0);
    chk("t6_clr_min",   Min_En, 0);
    chk("t6_clr_up",    Up, 0);
    chk("t6_clr_tick",  Tick, 0);
    chk("t6_clr_sec",   Sec_En, 0);
    chk("t6_clr_blink", Blink, 0);
    Clr = 1'b0;
    repeat (6) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
